// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer: state encoding,
// read-latency bounds, bus widths and requester port indices.
package mem_seq_pkg;

  localparam int ADDR_W        = 8;
  localparam int DATA_W        = 16;
  localparam int RD_CYCLES_MIN = 1;
  localparam int RD_CYCLES_MAX = 4;
  localparam int CNT_W         = $clog2(RD_CYCLES_MAX);

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic logic [DATA_W-1:0] zext_addr(input logic [ADDR_W-1:0] a);
    return {{(DATA_W-ADDR_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Requester handshakes, MDR read-back and datapath strobes of the sequencer.
// master = requesters plus MAR/MDR/RAM datapath, slave = the sequencer.
interface mem_access_sequencer_if;
  import mem_seq_pkg::*;

  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] bus_out;
  logic              bus_drive;
  logic              mar_in, mdr_in, mdr_out, ram_read, ram_write;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mdr_q,
    input  ack0, ack1, rd_data, busy, bus_out, bus_drive,
           mar_in, mdr_in, mdr_out, ram_read, ram_write
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mdr_q,
    output ack0, ack1, rd_data, busy, bus_out, bus_drive,
           mar_in, mdr_in, mdr_out, ram_read, ram_write
  );

endinterface

// File: rtl/mem_access_sequencer_arb.sv
// Two-port round-robin arbiter: on contention the port not served last wins.
module rr_arbiter2
  import mem_seq_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_served,
  input  logic       grant_en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_served == DATA) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences MAR/MDR/RAM strobes so the fetch and data ports share one memory path.
//   state | meaning
//   IDLE  | waiting for a request, arbiter enabled
//   ADDR  | address on bus, MAR_in
//   DATA  | write data on bus, MDR_in
//   READ  | RAM_read held for RD_CYCLES cycles
//   WRITE | RAM_write pulse
//   DONE  | ack to latched port; MDR_out on reads
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int RD_CYCLES = 2
) (
  input logic                    clk,
  input logic                    reset,
  mem_access_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic              port_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              last_served;
  logic [1:0]        grant;

  rr_arbiter2 u_arb (
    .req        ({bus.req1, bus.req0}),
    .last_served(last_served),
    .grant_en   (state == ST_IDLE),
    .grant      (grant)
  );

  assign bus.rd_data = bus.mdr_q;

  // Outputs are registered with the state they belong to, so each strobe
  // is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      rd_cnt        <= '0;
      port_q        <= FETCH;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      last_served   <= DATA;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.bus_out   <= '0;
      bus.bus_drive <= 1'b0;
      bus.mar_in    <= 1'b0;
      bus.mdr_in    <= 1'b0;
      bus.mdr_out   <= 1'b0;
      bus.ram_read  <= 1'b0;
      bus.ram_write <= 1'b0;
    end else begin
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.bus_out   <= '0;
      bus.bus_drive <= 1'b0;
      bus.mar_in    <= 1'b0;
      bus.mdr_in    <= 1'b0;
      bus.mdr_out   <= 1'b0;
      bus.ram_read  <= 1'b0;
      bus.ram_write <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            port_q        <= grant[1];
            we_q          <= grant[1] ? bus.we1 : bus.we0;
            wdata_q       <= grant[1] ? bus.wdata1 : bus.wdata0;
            bus.bus_out   <= zext_addr(grant[1] ? bus.addr1 : bus.addr0);
            bus.bus_drive <= 1'b1;
            bus.mar_in    <= 1'b1;
            bus.busy      <= 1'b1;
            state         <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          if (we_q) begin
            bus.bus_out   <= wdata_q;
            bus.bus_drive <= 1'b1;
            bus.mdr_in    <= 1'b1;
            state         <= ST_DATA;
          end else begin
            rd_cnt       <= RD_LOAD;
            bus.ram_read <= 1'b1;
            state        <= ST_READ;
          end
        end

        ST_DATA: begin
          bus.ram_write <= 1'b1;
          state         <= ST_WRITE;
        end

        ST_READ: begin
          if (rd_cnt == '0) begin
            bus.ack0    <= (port_q == FETCH);
            bus.ack1    <= (port_q == DATA);
            bus.mdr_out <= 1'b1;
            state       <= ST_DONE;
          end else begin
            rd_cnt       <= rd_cnt - 1'b1;
            bus.ram_read <= 1'b1;
          end
        end

        ST_WRITE: begin
          bus.ack0 <= (port_q == FETCH);
          bus.ack1 <= (port_q == DATA);
          state    <= ST_DONE;
        end

        ST_DONE: begin
          last_served <= port_q;
          bus.busy    <= 1'b0;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
